// File: rtl/jpeg_dezigzag_dequant.sv
// -----------------------------------------------------------------------------
// jpeg_dezigzag_dequant
//
// Purpose:
//   Sits between the JPEG entropy decoder and the IDCT. Takes one quantised
//   coefficient per cycle in zig-zag order, multiplies it by the matching
//   8-bit quantisation table entry and stores it at its raster position in a
//   ping-pong pair of 8x8 block buffers. Completed blocks are streamed out in
//   raster order over a valid/ready handshake. The input side never stalls;
//   data arriving while the target bank is still full is dropped and the
//   sticky overflow flag is raised.
//
// Configuration macro:
//   JPEG_DQ_SATURATE_EN  defined   : product saturated to [-32768, 32767]
//                        undefined : product wrapped to its low 16 bits
//
// Ports:
//   clk          in   1   clock
//   rst_n        in   1   asynchronous active-low reset
//   coeff_valid  in   1   coefficient present this cycle
//   coeff_index  in   6   zig-zag index 0..63
//   coeff_value  in  12   signed quantised coefficient
//   block_done   in   1   end of block (with or without a coefficient)
//   qt_wr_en     in   1   quant table write strobe
//   qt_wr_addr   in   6   quant table address (zig-zag order)
//   qt_wr_data   in   8   quant table value
//   out_valid    out  1   output coefficient valid
//   out_ready    in   1   IDCT accepts
//   out_data     out 16   signed dequantised coefficient
//   out_addr     out  6   raster index (row*8+col)
//   out_last     out  1   high with out_addr == 63
//   overflow     out  1   sticky: input dropped because both banks full
// -----------------------------------------------------------------------------
module jpeg_dezigzag_dequant (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               coeff_valid,
  input  logic [5:0]         coeff_index,
  input  logic signed [11:0] coeff_value,
  input  logic               block_done,
  input  logic               qt_wr_en,
  input  logic [5:0]         qt_wr_addr,
  input  logic [7:0]         qt_wr_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_data,
  output logic [5:0]         out_addr,
  output logic               out_last,
  output logic               overflow
);

  // Zig-zag index -> raster index (standard JPEG scan).
  localparam logic [5:0] ZZ_LUT [0:63] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_t;

  // ---------------------------------------------------------------------------
  // Quantisation table (registers, identity after reset). A lookup in the
  // same cycle as a write to that entry naturally returns the old value.
  // ---------------------------------------------------------------------------
  logic [7:0] r_qt [0:63];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) r_qt[i] <= 8'd1;
    end else if (qt_wr_en) begin
      r_qt[qt_wr_addr] <= qt_wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: input register with table lookups
  // ---------------------------------------------------------------------------
  logic               r_s1_valid;
  logic               r_s1_done;
  logic signed [11:0] r_s1_value;
  logic [5:0]         r_s1_nat;
  logic [7:0]         r_s1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_done  <= 1'b0;
      r_s1_value <= '0;
      r_s1_nat   <= '0;
      r_s1_q     <= '0;
    end else begin
      r_s1_valid <= coeff_valid;
      r_s1_done  <= block_done;
      r_s1_value <= coeff_value;
      r_s1_nat   <= ZZ_LUT[coeff_index];
      r_s1_q     <= r_qt[coeff_index];
    end
  end

  // ---------------------------------------------------------------------------
  // Multiply and reduce to 16 bits
  // ---------------------------------------------------------------------------
  logic signed [15:0] w_red;

`ifdef JPEG_DQ_SATURATE_EN
  logic signed [20:0] w_prod;
  assign w_prod = r_s1_value * $signed({1'b0, r_s1_q});

  always_comb begin
    w_red = w_prod[15:0];
    if (w_prod > 21'sd32767)
      w_red = 16'sh7FFF;
    else if (w_prod < -21'sd32768)
      w_red = 16'sh8000;
  end
`else
  // The low 16 bits of a product depend only on the low 16 bits of its
  // operands, so multiplying at output width yields the wrapped result.
  always_comb begin
    w_red = r_s1_value * $signed({1'b0, r_s1_q});
  end
`endif

  // ---------------------------------------------------------------------------
  // Stage 2: product register feeding the bank write
  // ---------------------------------------------------------------------------
  logic               r_s2_valid;
  logic               r_s2_done;
  logic [5:0]         r_s2_nat;
  logic signed [15:0] r_s2_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_done  <= 1'b0;
      r_s2_nat   <= '0;
      r_s2_data  <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_done  <= r_s1_done;
      r_s2_nat   <= r_s1_nat;
      r_s2_data  <= w_red;
    end
  end

  // ---------------------------------------------------------------------------
  // Bank bookkeeping
  // ---------------------------------------------------------------------------
  logic       r_wr_bank;
  logic       r_rd_bank;
  logic [1:0] r_full;
  logic [1:0] w_full_next;
  logic       r_overflow;
  rd_state_t  r_rd_state;
  rd_state_t  w_rd_state_next;
  logic [6:0] r_rd_ptr;      // bit 6 set once all 64 entries are loaded
  logic       r_out_valid;
  logic signed [15:0] r_out_data;
  logic [5:0] r_out_addr;
  logic       r_out_last;

  logic w_free;
  logic w_wr_full;
  logic w_mem_we;
  logic w_commit;
  logic w_drop;
  logic w_load;

  // Final element of the streaming bank handed over this cycle.
  assign w_free = (r_rd_state == RD_STREAM) && r_out_valid && out_ready && r_out_last;

  // A bank being freed this cycle already counts as empty for the writer.
  assign w_wr_full = r_full[r_wr_bank] && !(w_free && (r_rd_bank == r_wr_bank));
  assign w_mem_we  = r_s2_valid && !w_wr_full;
  assign w_commit  = r_s2_done  && !w_wr_full;
  assign w_drop    = (r_s2_valid || r_s2_done) && w_wr_full;

  always_comb begin
    w_full_next = r_full;
    if (w_free)
      w_full_next[r_rd_bank] = 1'b0;
    if (w_commit)
      w_full_next[r_wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full     <= 2'b00;
      r_wr_bank  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_full <= w_full_next;
      if (w_commit)
        r_wr_bank <= ~r_wr_bank;
      if (w_drop)
        r_overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Block buffer: both banks in one array, bank select is the address MSB.
  // ---------------------------------------------------------------------------
  logic signed [15:0] r_mem [0:127];

  always_ff @(posedge clk) begin
    if (w_mem_we)
      r_mem[{r_wr_bank, r_s2_nat}] <= r_s2_data;
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rd_state <= RD_IDLE;
    else
      r_rd_state <= w_rd_state_next;
  end

  always_comb begin
    w_rd_state_next = r_rd_state;
    case (r_rd_state)
      RD_IDLE:   if (r_full[r_rd_bank]) w_rd_state_next = RD_STREAM;
      RD_STREAM: if (w_free)            w_rd_state_next = RD_IDLE;
      default:                          w_rd_state_next = RD_IDLE;
    endcase
  end

  assign w_load = (r_rd_state == RD_STREAM) && !r_rd_ptr[6] && (!r_out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr  <= '0;
      r_rd_bank <= 1'b0;
    end else begin
      if (r_rd_state == RD_IDLE && r_full[r_rd_bank])
        r_rd_ptr <= '0;
      else if (w_load)
        r_rd_ptr <= r_rd_ptr + 7'd1;
      if (w_free)
        r_rd_bank <= ~r_rd_bank;
    end
  end

  // Output register doubles as the registered read of the block buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= r_mem[{r_rd_bank, r_rd_ptr[5:0]}];
      r_out_addr  <= r_rd_ptr[5:0];
      r_out_last  <= (r_rd_ptr[5:0] == 6'd63);
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;
  assign out_last  = r_out_last;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_jpeg_dezigzag_dequant.sv
// -----------------------------------------------------------------------------
// tb_jpeg_dezigzag_dequant
//
// Self-checking bench. A reference model derives raster positions by walking
// the 8x8 anti-diagonals and computes dequantised values with plain integer
// arithmetic; accepted outputs are captured by a monitor and compared in each
// scenario task.
// -----------------------------------------------------------------------------
module tb_jpeg_dezigzag_dequant;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               coeff_valid = 1'b0;
  logic [5:0]         coeff_index = '0;
  logic signed [11:0] coeff_value = '0;
  logic               block_done = 1'b0;
  logic               qt_wr_en = 1'b0;
  logic [5:0]         qt_wr_addr = '0;
  logic [7:0]         qt_wr_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] out_data;
  logic [5:0]         out_addr;
  logic               out_last;
  logic               overflow;

  always #5 clk = ~clk;

  jpeg_dezigzag_dequant dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coeff_valid (coeff_valid),
    .coeff_index (coeff_index),
    .coeff_value (coeff_value),
    .block_done  (block_done),
    .qt_wr_en    (qt_wr_en),
    .qt_wr_addr  (qt_wr_addr),
    .qt_wr_data  (qt_wr_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .out_last    (out_last),
    .overflow    (overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  int zz2nat [64];
  int blk_zz [64];
  int qt_m   [64];
  int exp_data [256];
  int exp_n;
  int got_addr [256];
  int got_data [256];
  int got_last [256];
  int got_n;
  bit rnd_ready = 1'b0;

  int cap_addr [$];
  int cap_data [$];
  int cap_last [$];

  // Monitor: a transfer happens at the next rising edge when valid & ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      cap_addr.push_back(int'(out_addr));
      cap_data.push_back(int'(out_data));
      cap_last.push_back(int'(out_last));
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d outputs, want completion", got_n);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Model
  // ---------------------------------------------------------------------------
  function automatic void build_zz();
    int r, c;
    r = 0; c = 0;
    for (int k = 0; k < 64; k++) begin
      zz2nat[k] = r * 8 + c;
      if (((r + c) % 2) == 0) begin
        if (c == 7) r++;
        else if (r == 0) c++;
        else begin r--; c++; end
      end else begin
        if (r == 7) c++;
        else if (c == 0) r++;
        else begin r++; c--; end
      end
    end
  endfunction

  function automatic int dq(input int v, input int q);
    int p;
    logic [31:0] u;
    logic signed [15:0] s;
    p = v * q;
`ifdef JPEG_DQ_SATURATE_EN
    if (p > 32767) return 32767;
    if (p < -32768) return -32768;
`endif
    u = p;
    s = u[15:0];
    return int'(s);
  endfunction

  // Append the raster-ordered expectation for blk_zz under the current table.
  function automatic void build_expected();
    int e [64];
    for (int k = 0; k < 64; k++) e[zz2nat[k]] = dq(blk_zz[k], qt_m[k]);
    for (int a = 0; a < 64; a++) exp_data[exp_n + a] = e[a];
    exp_n += 64;
  endfunction

  function automatic void rand_block();
    for (int k = 0; k < 64; k++) blk_zz[k] = int'($urandom_range(0, 4095)) - 2048;
  endfunction

  function automatic void zero_block();
    for (int k = 0; k < 64; k++) blk_zz[k] = 0;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    coeff_valid = 1'b0;
    block_done = 1'b0;
    qt_wr_en = 1'b0;
    out_ready = 1'b0;
    rnd_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    cap_addr.delete();
    cap_data.delete();
    cap_last.delete();
    for (int k = 0; k < 64; k++) qt_m[k] = 1;
    exp_n = 0;
    got_n = 0;
  endtask

  task automatic write_qt(input int k, input int v);
    qt_wr_en = 1'b1;
    qt_wr_addr = 6'(k);
    qt_wr_data = 8'(v);
    qt_m[k] = v;
    step();
    qt_wr_en = 1'b0;
  endtask

  task automatic send_block(input bit bare, input int ncoef);
    for (int k = 0; k < ncoef; k++) begin
      coeff_valid = 1'b1;
      coeff_index = 6'(k);
      coeff_value = 12'(blk_zz[k]);
      block_done  = (!bare && k == 63);
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      step();
    end
    coeff_valid = 1'b0;
    block_done  = 1'b0;
    if (bare) begin
      block_done = 1'b1;
      step();
      block_done = 1'b0;
    end
  endtask

  // Waits (bounded) for n accepted outputs and moves them into got_*.
  task automatic collect(input int n);
    int waited;
    waited = 0;
    got_n = 0;
    while (got_n < n && waited < n * 8 + 200) begin
      while (cap_data.size() > 0 && got_n < n) begin
        got_addr[got_n] = cap_addr.pop_front();
        got_data[got_n] = cap_data.pop_front();
        got_last[got_n] = cap_last.pop_front();
        got_n++;
      end
      if (got_n < n) begin
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        step();
        waited++;
      end
    end
    $display("collected %0d of %0d outputs", got_n, n);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got valid=%b overflow=%b, want 0 0", out_valid, overflow);
    end
    n_checks++;
    if (out_data !== 16'sd0 || out_addr !== 6'd0 || out_last !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got data=%0d addr=%0d last=%b, want 0 0 0", out_data, out_addr, out_last);
    end
    do_reset();
    n_checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: got valid=%b overflow=%b, want 0 0", out_valid, overflow);
    end
  endtask

  task automatic test_identity();
    do_reset();
    zero_block();
    blk_zz[0] = 100; blk_zz[1] = -5; blk_zz[2] = 7;
    build_expected();
    out_ready = 1'b1;
    send_block(1'b0, 64);
    repeat (3) step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL ident_early_valid: got %b at done+3, want 0", out_valid);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL ident_first_valid: got %b at done+4, want 1", out_valid);
    end
    collect(64);
    n_checks++;
    if (got_n !== 64) begin
      n_errors++;
      $display("FAIL ident_count: got %0d outputs, want 64", got_n);
    end
    for (int i = 0; i < got_n; i++) begin
      n_checks++;
      if (got_addr[i] !== i % 64 || got_data[i] !== exp_data[i] || got_last[i] !== int'(i % 64 == 63)) begin
        n_errors++;
        $display("FAIL ident_out[%0d]: got addr=%0d data=%0d last=%0d, want addr=%0d data=%0d last=%0d",
                 i, got_addr[i], got_data[i], got_last[i], i % 64, exp_data[i], int'(i % 64 == 63));
      end
    end
  endtask

  task automatic test_qt16();
    do_reset();
    for (int k = 0; k < 64; k++) write_qt(k, 16);
    zero_block();
    blk_zz[3] = -3;
    build_expected();
    out_ready = 1'b1;
    send_block(1'b0, 64);
    collect(64);
    n_checks++;
    if (got_n !== 64 || got_data[16] !== -48) begin
      n_errors++;
      $display("FAIL qt16_addr16: got count=%0d data=%0d, want 64 -48", got_n, got_data[16]);
    end
    for (int i = 0; i < got_n; i++) begin
      n_checks++;
      if (got_addr[i] !== i || got_data[i] !== exp_data[i]) begin
        n_errors++;
        $display("FAIL qt16_out[%0d]: got addr=%0d data=%0d, want addr=%0d data=%0d",
                 i, got_addr[i], got_data[i], i, exp_data[i]);
      end
    end
  endtask

  task automatic test_dc_sat();
    int want;
    do_reset();
    write_qt(0, 255);
    zero_block();
    blk_zz[0] = 2047;
    build_expected();
    out_ready = 1'b1;
    send_block(1'b0, 64);
    collect(64);
`ifdef JPEG_DQ_SATURATE_EN
    want = 32767;
`else
    want = -2303;   // 2047*255 = 0x7F701, low 16 bits 0xF701
`endif
    n_checks++;
    if (got_n !== 64 || got_data[0] !== want) begin
      n_errors++;
      $display("FAIL dc_reduce: got count=%0d data=%0d, want 64 %0d", got_n, got_data[0], want);
    end
    for (int i = 1; i < got_n; i++) begin
      n_checks++;
      if (got_data[i] !== exp_data[i]) begin
        n_errors++;
        $display("FAIL dc_rest[%0d]: got %0d, want %0d", i, got_data[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      rand_block();
      if (b < 2) build_expected();
      if (b == 2) begin
        n_checks++;
        if (overflow !== 1'b0) begin
          n_errors++;
          $display("FAIL b2b_no_early_overflow: got %b, want 0", overflow);
        end
      end
      send_block(1'b0, 64);
    end
    repeat (3) step();
    n_checks++;
    if (overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_overflow: got %b, want 1", overflow);
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_addr !== 6'd0 || out_data !== 16'(exp_data[0])) begin
      n_errors++;
      $display("FAIL b2b_hold: got valid=%b addr=%0d data=%0d, want 1 0 %0d", out_valid, out_addr, out_data, exp_data[0]);
    end
    out_ready = 1'b1;
    collect(128);
    n_checks++;
    if (got_n !== 128) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d outputs, want 128", got_n);
    end
    for (int i = 0; i < got_n; i++) begin
      n_checks++;
      if (got_addr[i] !== i % 64 || got_data[i] !== exp_data[i] || got_last[i] !== int'(i % 64 == 63)) begin
        n_errors++;
        $display("FAIL b2b_out[%0d]: got addr=%0d data=%0d last=%0d, want addr=%0d data=%0d",
                 i, got_addr[i], got_data[i], got_last[i], i % 64, exp_data[i]);
      end
    end
    repeat (300) step();
    n_checks++;
    if (cap_data.size() !== 0 || out_valid !== 1'b0 || overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_tail: got extra=%0d valid=%b overflow=%b, want 0 0 1", cap_data.size(), out_valid, overflow);
    end
  endtask

  task automatic test_ready_toggle();
    bit prev_v, prev_r, prev_l;
    int prev_d, prev_a;
    do_reset();
    rand_block();
    build_expected();
    out_ready = 1'b0;
    send_block(1'b0, 64);
    prev_v = 1'b0; prev_r = 1'b0; prev_l = 1'b0; prev_d = 0; prev_a = 0;
    for (int c = 0; c < 600 && cap_data.size() < 64; c++) begin
      if (prev_v && !prev_r) begin
        n_checks++;
        if (out_valid !== 1'b1 || int'(out_data) !== prev_d || int'(out_addr) !== prev_a || out_last !== prev_l) begin
          n_errors++;
          $display("FAIL toggle_stable: got valid=%b addr=%0d data=%0d, want 1 %0d %0d",
                   out_valid, out_addr, out_data, prev_a, prev_d);
        end
      end
      prev_v = out_valid;
      prev_d = int'(out_data);
      prev_a = int'(out_addr);
      prev_l = out_last;
      out_ready = ~out_ready;
      prev_r = out_ready;
      step();
    end
    out_ready = 1'b0;
    collect(64);
    n_checks++;
    if (got_n !== 64) begin
      n_errors++;
      $display("FAIL toggle_count: got %0d outputs, want 64", got_n);
    end
    for (int i = 0; i < got_n; i++) begin
      n_checks++;
      if (got_addr[i] !== i || got_data[i] !== exp_data[i] || got_last[i] !== int'(i == 63)) begin
        n_errors++;
        $display("FAIL toggle_out[%0d]: got addr=%0d data=%0d last=%0d, want addr=%0d data=%0d",
                 i, got_addr[i], got_data[i], got_last[i], i, exp_data[i]);
      end
    end
    out_ready = 1'b1;
    repeat (150) step();
    n_checks++;
    if (cap_data.size() !== 0) begin
      n_errors++;
      $display("FAIL toggle_dup: got %0d extra outputs, want 0", cap_data.size());
    end
  endtask

  task automatic test_bare_done();
    do_reset();
    rand_block();
    build_expected();
    out_ready = 1'b1;
    send_block(1'b1, 64);
    repeat (3) step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bare_early_valid: got %b at done+3, want 0", out_valid);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL bare_first_valid: got %b at done+4, want 1", out_valid);
    end
    collect(64);
    for (int i = 0; i < got_n; i++) begin
      n_checks++;
      if (got_addr[i] !== i || got_data[i] !== exp_data[i] || got_last[i] !== int'(i == 63)) begin
        n_errors++;
        $display("FAIL bare_out[%0d]: got addr=%0d data=%0d last=%0d, want addr=%0d data=%0d",
                 i, got_addr[i], got_data[i], got_last[i], i, exp_data[i]);
      end
    end
    repeat (150) step();
    n_checks++;
    if (got_n !== 64 || cap_data.size() !== 0 || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL bare_single: got count=%0d extra=%0d overflow=%b, want 64 0 0", got_n, cap_data.size(), overflow);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 4; it++) begin
      exp_n = 0;
      rnd_ready = 1'b0;
      out_ready = 1'b0;
      for (int k = 0; k < 64; k++) write_qt(k, int'($urandom_range(0, 255)));
      rnd_ready = 1'b1;
      rand_block();
      build_expected();
      send_block(1'b0, 64);
      rand_block();
      build_expected();
      send_block(1'(it % 2), 64);
      collect(128);
      n_checks++;
      if (got_n !== 128 || overflow !== 1'b0) begin
        n_errors++;
        $display("FAIL rand_count[%0d]: got count=%0d overflow=%b, want 128 0", it, got_n, overflow);
      end
      for (int i = 0; i < got_n; i++) begin
        n_checks++;
        if (got_addr[i] !== i % 64 || got_data[i] !== exp_data[i] || got_last[i] !== int'(i % 64 == 63)) begin
          n_errors++;
          $display("FAIL rand_out[%0d][%0d]: got addr=%0d data=%0d last=%0d, want addr=%0d data=%0d",
                   it, i, got_addr[i], got_data[i], got_last[i], i % 64, exp_data[i]);
        end
      end
    end
    rnd_ready = 1'b0;
  endtask

  task automatic test_reset_mid_block();
    do_reset();
    out_ready = 1'b0;
    rand_block();
    send_block(1'b0, 64);
    rand_block();
    send_block(1'b0, 30);
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 16'sd0 || out_addr !== 6'd0 || out_last !== 1'b0 || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_async: got valid=%b data=%0d addr=%0d last=%b ovf=%b, want all 0",
               out_valid, out_data, out_addr, out_last, overflow);
    end
    step();
    rst_n = 1'b1;
    cap_data.delete();
    cap_addr.delete();
    cap_last.delete();
    out_ready = 1'b1;
    repeat (200) step();
    n_checks++;
    if (cap_data.size() !== 0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_lost: got outputs=%0d valid=%b overflow=%b, want 0 0 0", cap_data.size(), out_valid, overflow);
    end
  endtask

  initial begin
    build_zz();
    for (int k = 0; k < 64; k++) qt_m[k] = 1;
    test_reset();
    test_identity();
    test_qt16();
    test_dc_sat();
    test_back_to_back();
    test_ready_toggle();
    test_bare_done();
    test_random();
    test_reset_mid_block();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
